// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 keyboard front end: scan-code prefixes,
// the tracked-key map and the frame receiver state encoding.
package ps2_key_pkg;

    localparam int NUM_KEYS = 10;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_AA = 8'hAA;

    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_ESC   = 9'h076;
    localparam logic [8:0] KEY_R     = 9'h02D;
    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_DOWN  = 9'h172;
    localparam logic [8:0] KEY_RIGHT = 9'h174;
    localparam logic [8:0] KEY_A     = 9'h01C;
    localparam logic [8:0] KEY_D     = 9'h023;

    // Position in this array is the key_down bit index (KEY_MAP[0] = space).
    localparam logic [NUM_KEYS-1:0][8:0] KEY_MAP = {
        KEY_D, KEY_A, KEY_RIGHT, KEY_DOWN, KEY_LEFT,
        KEY_UP, KEY_R, KEY_ESC, KEY_ENTER, KEY_SPACE
    };

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, ps2_clk deglitch filter,
// 11-bit frame FSM with odd-parity/stop check and mid-frame timeout.
module ps2_rx_frame
    import ps2_key_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync, data_sync;
    logic          s_clk, s_data;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fedge;
    rx_state_t     state, state_nx;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_hit, stop_seen, frame_ok;

    assign s_clk  = clk_sync[1];
    assign s_data = data_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt_clk  <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            if (s_clk == filt_clk)
                filt_cnt <= '0;
            else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= s_clk;
                filt_cnt <= '0;
            end else
                filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Strobe in the cycle the filtered clock is about to fall.
    assign fedge       = filt_clk && !s_clk && (filt_cnt == FW'(FILTER_LEN - 1));
    assign timeout_hit = (state != IDLE) && !fedge && (tmo_cnt == TW'(TIMEOUT - 1));
    assign stop_seen   = (state == STOP) && fedge;
    assign frame_ok    = s_data && (^{shreg, parity});

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fedge && !s_data)            state_nx = DATA;
            DATA:    if (fedge && bit_cnt == 3'd7)    state_nx = PARITY;
            PARITY:  if (fedge)                       state_nx = STOP;
            STOP:    if (fedge)                       state_nx = IDLE;
            default:                                  state_nx = IDLE;
        endcase
        if (timeout_hit) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            tmo_cnt    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= stop_seen && frame_ok;
            frame_err  <= (stop_seen && !frame_ok) || timeout_hit;
            // tmo_cnt holds the number of cycles since the last fedge.
            if (fedge)              tmo_cnt <= TW'(1);
            else if (state != IDLE) tmo_cnt <= tmo_cnt + 1'b1;
            else                    tmo_cnt <= '0;
            if (fedge) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {s_data, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: parity <= s_data;
                    default: ;
                endcase
            end
        end
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/ps2_key_tracker.sv
// Keyboard front end: decodes make/break/E0 sequences from the PS/2 receiver
// into the key_down level vector plus a per-event strobe and code.
module ps2_key_tracker
    import ps2_key_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [8:0]          last_change,
    output logic                key_valid,
    output logic                frame_err
);
    logic                byte_valid;
    logic [7:0]          rx_byte;
    logic                ext, brk;
    logic [8:0]          code;
    logic [NUM_KEYS-1:0] hit;
    logic                report;

    ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    assign code = {ext, rx_byte};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_map
        assign hit[i] = (code == KEY_MAP[i]);
    end

    // Bare FA/AA are keyboard ack / self-test replies, not key events.
    assign report = byte_valid && (rx_byte != SC_E0) && (rx_byte != SC_F0) &&
                    !((rx_byte == SC_FA || rx_byte == SC_AA) && !ext && !brk);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_down    <= '0;
            last_change <= '0;
            key_valid   <= 1'b0;
            ext         <= 1'b0;
            brk         <= 1'b0;
        end else begin
            key_valid <= report;
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte == SC_E0) ext <= 1'b1;
                if (rx_byte == SC_F0) brk <= 1'b1;
                if (report) begin
                    last_change <= code;
                    key_down    <= (key_down & ~hit) | (hit & {NUM_KEYS{~brk}});
                    ext         <= 1'b0;
                    brk         <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Keyboard front end. Receives PS/2 frames from the keyboard and decodes make (key pressed), break (key released) and extended (E0) scan-code sequences.
- Keeps the key_down[9:0] level vector that the player and game-control logic consume.
- Also reports each key event as a one-cycle strobe plus the code that changed.
- Sits between the PS/2 pins and every key_down consumer.

Parameters:
- FILTER_LEN, 8: clk cycles ps2_clk must hold a new level before the filtered edge is accepted.
- TIMEOUT, 100000: clk cycles with no filtered falling edge mid-frame before the frame is aborted (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data pin, asynchronous to clk.
- key_down  out  10  level per tracked key; 1 = held.
- last_change  out  9  {ext, code[7:0]} of the latest non-prefix byte.
- key_valid  out  1  one-cycle strobe when last_change updates.
- frame_err  out  1  one-cycle strobe when a frame is aborted.

Behaviour:
- Reset (rst low, asynchronous):
  - key_down=0, last_change=0, key_valid=0, frame_err=0.
  - Receiver goes to IDLE; ext/brk flags cleared; filter loaded high.
  - Reset mid-frame discards all partial data.
- Input sync: ps2_clk and ps2_data pass through 2-FF synchronisers.
- Clock filter: filt_clk changes only after synced ps2_clk differs from filt_clk for FILTER_LEN consecutive cycles. A shorter glitch produces no edge. A filt_clk 1->0 transition is the one-cycle "fedge" strobe, and synced ps2_data is sampled on it.
- Receiver FSM (in ps2_rx_frame), bits arrive LSB first:
  - IDLE: on fedge, if data=0 go to DATA with bit count 0; if data=1 stay in IDLE (no error).
  - DATA: 8 fedges shift data bits in; go to PARITY after the 8th.
  - PARITY: on fedge capture the parity bit; go to STOP.
  - STOP: on fedge the frame is good if stop=1 and XOR(data,parity)=1 (odd parity). Good frame: byte_valid pulses on the next cycle with byte[7:0]. Bad frame: frame_err pulses instead. Return to IDLE either way.
  - Timeout: in DATA/PARITY/STOP, a counter resets on every fedge. When it reaches TIMEOUT-1 without a fedge, pulse frame_err and go to IDLE.
  - Any frame_err also clears the decoder's ext/brk flags in the same cycle.
- Decoder, acting on byte_valid:
  - E0: ext<=1. No strobe.
  - F0: brk<=1. No strobe.
  - FA or AA with ext=brk=0: ignored (ack / self-test). No strobe.
  - Any other byte (latency: registered one cycle after byte_valid, i.e. 2 clk after the stop-bit fedge):
    - last_change<={ext,byte}; key_valid pulses.
    - If {ext,byte} is in the key map, key_down[idx]<=~brk. Unmapped codes leave key_down unchanged.
    - ext and brk clear.
- A repeated make of a held key keeps its bit at 1 and still pulses key_valid. A break for a key not held keeps the bit at 0 and still pulses key_valid.
- Each byte updates exactly one index, so key_down changes only on mapped events.
- Key map (package constants), index: {ext,code}:
  - 0: 0_29 space
  - 1: 0_5A enter
  - 2: 0_76 esc
  - 3: 0_2D R
  - 4: 1_75 up
  - 5: 1_6B left
  - 6: 1_72 down
  - 7: 1_74 right
  - 8: 0_1C A
  - 9: 0_23 D
- key_valid and frame_err are never asserted in the same cycle.

Decomposition:
- Package ps2_key_pkg:
  - prefix constants E0, F0, FA, AA;
  - the ten 9-bit key-map codes and their indices;
  - the receiver state encoding (IDLE, DATA, PARITY, STOP).
- Sub-module ps2_rx_frame (sync, filter, FSM, timeout) outputs byte_valid, byte, frame_err.
- The top level holds the decoder flags, the key-map lookup and the output registers.

Test Plan:
- Frames E0, 75 sent at a 12.5 kHz PS/2 clock: key_down=10'h010 two clk after the second stop-bit fedge; last_change=9'h175; key_valid pulses once.
- Then E0, F0, 75: key_down=0; last_change=9'h175; one key_valid; no strobe on either prefix byte.
- 1C make then 23 make (both held): key_down=10'h300. Then F0 1C: key_down=10'h200.
- Frame 29 sent with even parity: frame_err pulses once; key_down unchanged; no key_valid. A following clean 29 gives key_down[0]=1.
- Data stops after 4 data bits: frame_err pulses exactly TIMEOUT cycles after the last fedge. A following clean 5A gives key_down[1]=1.
- Negative glitch on ps2_clk of FILTER_LEN-1 cycles during IDLE and DATA: no state change. rst low mid-frame: all outputs 0, next complete frame decoded correctly.
